// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - states, opcode/funct constants and ALU codes for the multi-cycle MIPS core
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
  } state_t;

  typedef enum logic [1:0] {SRCB_REG, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH} srcb_t;
  typedef enum logic [1:0] {PC_ALU, PC_ALUOUT, PC_JUMP} pcsrc_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic funct_supported(input logic [5:0] funct);
    return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

  function automatic logic [2:0] funct_to_alu(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - FSM sequencing fetch, decode, execute, memory and write-back phases
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int ALUControl_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [5:0]                  opcode,
  input  logic [5:0]                  funct,
  input  logic                        mem_ready,
  input  logic                        zero,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic                        iord,
  output logic                        ir_we,
  output logic                        pc_we,
  output pcsrc_t                      pc_src,
  output logic                        mdr_we,
  output logic                        ab_we,
  output logic                        aluout_we,
  output logic                        alu_srca,
  output srcb_t                       alu_srcb,
  output logic [ALUControl_WIDTH-1:0] alu_ctrl,
  output logic                        reg_we,
  output logic                        reg_dst,
  output logic                        mem_to_reg,
  output logic                        instr_done,
  output logic                        illegal_instr
);

  state_t state, next_state;
  logic   done_next, illegal_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_FETCH;
      instr_done    <= 1'b0;
      illegal_instr <= 1'b0;
    end else begin
      state         <= next_state;
      instr_done    <= done_next;
      illegal_instr <= illegal_next;
    end
  end

  always_comb begin
    next_state   = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    iord         = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_ALU;
    mdr_we       = 1'b0;
    ab_we        = 1'b0;
    aluout_we    = 1'b0;
    alu_srca     = 1'b0;
    alu_srcb     = SRCB_REG;
    alu_ctrl     = ALUControl_WIDTH'(ALU_ADD);
    reg_we       = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    done_next    = 1'b0;
    illegal_next = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        alu_srcb = SRCB_FOUR;
        if (mem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        // pc already holds instr+4, so this is the branch target
        ab_we      = 1'b1;
        aluout_we  = 1'b1;
        alu_srcb   = SRCB_IMM_SH;
        next_state = S_FETCH;
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          OP_RTYPE: begin
            if (funct_supported(funct)) next_state = S_EXECUTE;
            else                        illegal_next = 1'b1;
          end
          default:      illegal_next = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_srca   = 1'b1;
        alu_srcb   = SRCB_IMM;
        aluout_we  = 1'b1;
        next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          mdr_we     = 1'b1;
          next_state = S_MEMWB;
        end
      end
      S_MEMWB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        done_next  = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          done_next  = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alu_srca   = 1'b1;
        alu_ctrl   = ALUControl_WIDTH'(funct_to_alu(funct));
        aluout_we  = 1'b1;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we     = 1'b1;
        reg_dst    = 1'b1;
        done_next  = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_srca   = 1'b1;
        alu_ctrl   = ALUControl_WIDTH'(ALU_SUB);
        pc_src     = PC_ALUOUT;
        pc_we      = zero;
        done_next  = 1'b1;
        next_state = S_FETCH;
      end
      S_ADDIEX: begin
        alu_srca   = 1'b1;
        alu_srcb   = SRCB_IMM;
        aluout_we  = 1'b1;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_we     = 1'b1;
        done_next  = 1'b1;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = PC_JUMP;
        pc_we      = 1'b1;
        done_next  = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multi-cycle MIPS datapath, register file and shared memory port
module mips_multicycle_core
  import mips_mc_pkg::*;
#(
  parameter int                   MIPS_SIZE        = 32,
  parameter int                   RegAdd_WIDTH     = 5,
  parameter int                   ALUControl_WIDTH = 3,
  parameter logic [MIPS_SIZE-1:0] RESET_PC         = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  output logic [MIPS_SIZE-1:0] mem_addr,
  output logic [MIPS_SIZE-1:0] mem_wdata,
  input  logic [MIPS_SIZE-1:0] mem_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  input  logic                 mem_ready,
  output logic [MIPS_SIZE-1:0] pc,
  output logic                 instr_done,
  output logic                 illegal_instr
);

  localparam int NREG = 2**RegAdd_WIDTH;

  logic [MIPS_SIZE-1:0] pc_q, ir, mdr, a_q, b_q, alu_out_q;
  logic [MIPS_SIZE-1:0] rf [NREG];
  logic [MIPS_SIZE-1:0] signimm, alu_a, alu_b, alu_y, pc_next, wb_data;
  logic [RegAdd_WIDTH-1:0] rs, rt, rd, wa;

  logic   ctrl_req, ctrl_we, iord, ir_we, pc_we, mdr_we, ab_we, aluout_we;
  logic   alu_srca, reg_we, reg_dst, mem_to_reg, zero;
  pcsrc_t pc_src;
  srcb_t  alu_srcb;
  logic [ALUControl_WIDTH-1:0] alu_ctrl;

  mips_mc_ctrl #(.ALUControl_WIDTH(ALUControl_WIDTH)) u_ctrl (
    .clk          (CLK),
    .rst_n        (RST),
    .opcode       (ir[31:26]),
    .funct        (ir[5:0]),
    .mem_ready    (mem_ready),
    .zero         (zero),
    .mem_req      (ctrl_req),
    .mem_we       (ctrl_we),
    .iord         (iord),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .mdr_we       (mdr_we),
    .ab_we        (ab_we),
    .aluout_we    (aluout_we),
    .alu_srca     (alu_srca),
    .alu_srcb     (alu_srcb),
    .alu_ctrl     (alu_ctrl),
    .reg_we       (reg_we),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .instr_done   (instr_done),
    .illegal_instr(illegal_instr)
  );

  assign rs      = ir[21 +: RegAdd_WIDTH];
  assign rt      = ir[16 +: RegAdd_WIDTH];
  assign rd      = ir[11 +: RegAdd_WIDTH];
  assign signimm = {{(MIPS_SIZE-16){ir[15]}}, ir[15:0]};
  assign wa      = reg_dst ? rd : rt;
  assign wb_data = mem_to_reg ? mdr : alu_out_q;
  assign alu_a   = alu_srca ? a_q : pc_q;
  assign zero    = (alu_y == '0);

  // FSM sits in FETCH during reset, so the request is gated to drop it at once
  assign mem_req   = ctrl_req & RST;
  assign mem_we    = ctrl_we & RST;
  assign mem_addr  = iord ? alu_out_q : pc_q;
  assign mem_wdata = b_q;
  assign pc        = pc_q;

  always_comb begin
    case (alu_srcb)
      SRCB_REG:  alu_b = b_q;
      SRCB_FOUR: alu_b = MIPS_SIZE'(4);
      SRCB_IMM:  alu_b = signimm;
      default:   alu_b = signimm << 2;
    endcase
  end

  always_comb begin
    alu_y = '0;
    case (alu_ctrl)
      ALUControl_WIDTH'(ALU_ADD): alu_y = alu_a + alu_b;
      ALUControl_WIDTH'(ALU_SUB): alu_y = alu_a - alu_b;
      ALUControl_WIDTH'(ALU_AND): alu_y = alu_a & alu_b;
      ALUControl_WIDTH'(ALU_OR):  alu_y = alu_a | alu_b;
      ALUControl_WIDTH'(ALU_SLT): alu_y = {{(MIPS_SIZE-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      default:                    alu_y = '0;
    endcase
  end

  always_comb begin
    case (pc_src)
      PC_ALUOUT: pc_next = alu_out_q;
      PC_JUMP:   pc_next = {pc_q[MIPS_SIZE-1:28], ir[25:0], 2'b00};
      default:   pc_next = alu_y;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_q      <= RESET_PC;
      ir        <= '0;
      mdr       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
    end else begin
      if (pc_we)     pc_q      <= pc_next;
      if (ir_we)     ir        <= mem_rdata;
      if (mdr_we)    mdr       <= mem_rdata;
      if (aluout_we) alu_out_q <= alu_y;
      if (ab_we) begin
        a_q <= rf[rs];
        b_q <= rf[rt];
      end
    end
  end

  // register 0 is never written, so it reads zero from reset onward
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (reg_we && (wa != '0)) begin
      rf[wa] <= wb_data;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb/tb_mips_multicycle_core.sv - scoreboard bench for the multi-cycle MIPS core
module tb_mips_multicycle_core;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic        mem_req, mem_we, mem_ready, instr_done, illegal_instr;

  logic [31:0] mem [256];
  int          n_vec = 0;
  int          n_bad = 0;
  int          stall = 0;

  typedef struct {
    bit          illegal;
    logic [31:0] lat;
    logic [31:0] pc;
    logic [4:0]  ridx;
    logic [31:0] rval;
  } exp_t;

  exp_t        exp_q [$];
  logic [63:0] wr_q  [$];

  mips_multicycle_core dut (
    .CLK          (CLK),
    .RST          (RST),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_ready    (mem_ready),
    .pc           (pc),
    .instr_done   (instr_done),
    .illegal_instr(illegal_instr)
  );

  always #5 CLK = ~CLK;

  assign mem_rdata = mem[mem_addr[9:2]];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endfunction

  function automatic void expect_retire(input bit ill, input logic [31:0] lat, input logic [31:0] p,
                                        input logic [4:0] r, input logic [31:0] v);
    exp_t e;
    e.illegal = ill;
    e.lat     = lat;
    e.pc      = p;
    e.ridx    = r;
    e.rval    = v;
    exp_q.push_back(e);
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[9:2]] = w;
  endtask

  task automatic wait_retires(input int n);
    int seen = 0;
    int t    = 0;
    while (seen < n && t < 300) begin
      @(posedge CLK); #1;
      t++;
      if (instr_done || illegal_instr) seen++;
    end
    if (seen < n) begin
      n_vec++;
      n_bad++;
      $display("FAIL retire_timeout: got %0d retirements, required %0d", seen, n);
    end
  endtask

  // memory: commits writes at the edge, chooses mem_ready for the next cycle at the falling edge
  initial begin : mem_model
    bit          busy;
    int          waits;
    logic [63:0] w;
    busy      = 1'b0;
    waits     = 0;
    mem_ready = 1'b0;
    forever begin
      @(posedge CLK);
      if (RST && mem_req && mem_ready) begin
        busy = 1'b0;
        if (mem_we) begin
          if (wr_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_write: got addr %h data %h, required none", mem_addr, mem_wdata);
          end else begin
            w = wr_q.pop_front();
            check("write_addr", mem_addr, w[63:32]);
            check("write_data", mem_wdata, w[31:0]);
          end
          mem[mem_addr[9:2]] = mem_wdata;
        end
      end
      @(negedge CLK);
      if (mem_req) begin
        if (!busy) begin
          busy  = 1'b1;
          waits = stall;
        end
        if (waits > 0) begin
          mem_ready = 1'b0;
          waits--;
        end else begin
          mem_ready = 1'b1;
        end
      end else begin
        busy      = 1'b0;
        mem_ready = ($urandom_range(0, 1) == 1);
      end
    end
  end

  initial begin : monitor
    logic [31:0] cnt;
    exp_t        e;
    cnt = 0;
    forever begin
      @(posedge CLK); #1;
      if (!RST) begin
        cnt = 0;
      end else begin
        cnt++;
        if (instr_done || illegal_instr) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_retire: got pc %h, required none", pc);
          end else begin
            e = exp_q.pop_front();
            check("retire_kind", 32'({instr_done, illegal_instr}), e.illegal ? 32'd1 : 32'd2);
            check("retire_pc", pc, e.pc);
            check("retire_latency", cnt, e.lat);
            check($sformatf("retire_reg%0d", e.ridx), dut.rf[e.ridx], e.rval);
          end
          cnt = 0;
        end
      end
    end
  end

  initial begin : stimulus
    foreach (mem[i]) mem[i] = '1;
    put(32'h000, 32'h20010005);  // addi $1,$0,5
    put(32'h004, 32'h2002FFFD);  // addi $2,$0,-3
    put(32'h008, 32'h00221820);  // add  $3,$1,$2
    put(32'h00C, 32'h0041202A);  // slt  $4,$2,$1
    put(32'h010, 32'hAC030008);  // sw   $3,8($0)
    put(32'h014, 32'h8C050008);  // lw   $5,8($0)
    put(32'h018, 32'h20000007);  // addi $0,$0,7
    put(32'h01C, 32'h00223022);  // sub  $6,$1,$2
    put(32'h020, 32'h10210002);  // beq  $1,$1,+2
    put(32'h02C, 32'h08000040);  // j    0x40
    put(32'h100, 32'h10220005);  // beq  $1,$2,+5
    put(32'h104, 32'h00263825);  // or   $7,$1,$6
    put(32'h108, 32'h00464024);  // and  $8,$2,$6
    put(32'h10C, 32'h8C090008);  // lw   $9,8($0)
    put(32'h110, 32'hFC005020);  // unsupported opcode
    put(32'h114, 32'hAC060300);  // sw   $6,0x300($0)

    expect_retire(1'b0, 4,  32'h004, 5'd1,  32'd5);
    expect_retire(1'b0, 4,  32'h008, 5'd2,  32'hFFFFFFFD);
    expect_retire(1'b0, 4,  32'h00C, 5'd3,  32'd2);
    expect_retire(1'b0, 4,  32'h010, 5'd4,  32'd1);
    expect_retire(1'b0, 4,  32'h014, 5'd3,  32'd2);
    expect_retire(1'b0, 5,  32'h018, 5'd5,  32'd2);
    expect_retire(1'b0, 4,  32'h01C, 5'd0,  32'd0);
    expect_retire(1'b0, 4,  32'h020, 5'd6,  32'd8);
    expect_retire(1'b0, 3,  32'h02C, 5'd1,  32'd5);
    expect_retire(1'b0, 3,  32'h100, 5'd1,  32'd5);
    expect_retire(1'b0, 3,  32'h104, 5'd2,  32'hFFFFFFFD);
    expect_retire(1'b0, 4,  32'h108, 5'd7,  32'd13);
    expect_retire(1'b0, 4,  32'h10C, 5'd8,  32'd8);
    expect_retire(1'b0, 11, 32'h110, 5'd9,  32'd2);
    expect_retire(1'b1, 2,  32'h114, 5'd10, 32'd0);
    wr_q.push_back({32'h8, 32'h2});

    repeat (3) @(posedge CLK);
    #1;
    check("in_reset_mem_req", 32'(mem_req), 32'd0);
    check("in_reset_instr_done", 32'(instr_done), 32'd0);
    #1 RST = 1'b1;
    #1;
    check("first_cycle_pc", pc, 32'h0);
    check("first_cycle_mem_req", 32'(mem_req), 32'd1);
    check("first_cycle_mem_addr", mem_addr, 32'h0);
    check("first_cycle_mem_we", 32'(mem_we), 32'd0);
    check("first_cycle_instr_done", 32'(instr_done), 32'd0);

    wait_retires(13);
    stall = 3;
    for (int i = 0; i < 4; i++) begin
      check("fetch_wait_addr", mem_addr, 32'h10C);
      check("fetch_wait_req", 32'(mem_req), 32'd1);
      @(posedge CLK); #1;
    end
    repeat (2) begin
      @(posedge CLK); #1;
    end
    for (int i = 0; i < 4; i++) begin
      check("memrd_wait_addr", mem_addr, 32'h8);
      check("memrd_wait_we", 32'(mem_we), 32'd0);
      check("memrd_wait_reg9", dut.rf[9], 32'd0);
      @(posedge CLK); #1;
    end
    stall = 0;
    wait_retires(1);

    wait_retires(1);
    @(posedge CLK); #1;
    stall = 5;
    repeat (2) begin
      @(posedge CLK); #1;
    end
    check("memwr_req", 32'(mem_req), 32'd1);
    check("memwr_we", 32'(mem_we), 32'd1);
    check("memwr_addr", mem_addr, 32'h300);
    check("memwr_wdata", mem_wdata, 32'd8);
    @(posedge CLK); #1;
    check("memwr_held_addr", mem_addr, 32'h300);
    #2 RST = 1'b0;
    #1;
    check("mid_reset_mem_req", 32'(mem_req), 32'd0);
    check("mid_reset_mem_we", 32'(mem_we), 32'd0);
    check("mid_reset_pc", pc, 32'h0);
    check("mid_reset_reg6", dut.rf[6], 32'd0);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check("restart_pc", pc, 32'h0);
    check("restart_mem_req", 32'(mem_req), 32'd1);
    check("restart_mem_addr", mem_addr, 32'h0);
    check("abandoned_store", mem[8'hC0], 32'hFFFFFFFF);
    check("retires_outstanding", 32'(exp_q.size()), 32'd0);
    check("writes_outstanding", 32'(wr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Parametrised multi-cycle MIPS core: datapath and FSM controller in one block, sharing one ALU and one memory port across instruction phases.
- Next generation after the single-cycle datapath: the one memory port serves both instruction and data.
- Memory accesses use a req/ready handshake, so wait-state memories stall the core.
- Sits between the top-level memory wrapper and the debug/testbench harness.

Parameters:
- MIPS_SIZE, 32, datapath/register/address width
- RegAdd_WIDTH, 5, register address width; register file has 2**RegAdd_WIDTH entries
- ALUControl_WIDTH, 3, ALU control code width
- RESET_PC, 0, PC value loaded on reset

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  asynchronous, active-low reset
- mem_addr  out  MIPS_SIZE  byte address: PC in fetch, ALUOut in load/store
- mem_wdata  out  MIPS_SIZE  store data (register B)
- mem_rdata  in  MIPS_SIZE  read data; valid in the cycle mem_req&mem_ready
- mem_req  out  1  access request; held high until accepted
- mem_we  out  1  write qualifier; valid only while mem_req=1
- mem_ready  in  1  access completes in the cycle mem_req&mem_ready
- pc  out  MIPS_SIZE  current PC
- instr_done  out  1  one-cycle pulse on the cycle an instruction retires
- illegal_instr  out  1  one-cycle pulse when Decode sees an unsupported opcode/funct

Behaviour:
- Supported instructions:
  - R-type add, sub, and, or, slt.
  - lw, sw, beq, addi, j.
- ALU codes: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- Reset (RST=0, async): state=FETCH, pc=RESET_PC, IR/MDR/A/B/ALUOut=0, all registers=0, mem_req=0, mem_we=0, instr_done=0, illegal_instr=0.
- Register 0 always reads 0; writes to it are discarded.
- Register file reads are combinational; writes occur on the edge.
- FSM states and transitions:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ready: IR<=mem_rdata, pc<=pc+4 -> DECODE. No ready: stay, all registers hold.
  - DECODE: A<=rs, B<=rt, ALUOut<=pc+(signimm<<2), i.e. branch target with pc already +4.
    - lw/sw -> MEMADR
    - R-type -> EXECUTE
    - beq -> BRANCH
    - addi -> ADDIEX
    - j -> JUMP
    - otherwise pulse illegal_instr -> FETCH; pc stays at instruction+4.
  - MEMADR: ALUOut<=A+signimm -> MEMRD (lw) or MEMWR (sw).
  - MEMRD: mem_req=1, mem_addr=ALUOut. On ready: MDR<=mem_rdata -> MEMWB.
  - MEMWB: rt<=MDR, pulse instr_done -> FETCH.
  - MEMWR: mem_req=1, mem_we=1, mem_addr=ALUOut, mem_wdata=B. On ready: pulse instr_done -> FETCH.
  - EXECUTE: ALUOut<=A op B, op from funct -> ALUWB.
  - ALUWB: rd<=ALUOut, pulse instr_done -> FETCH.
  - BRANCH: compute A-B; if zero, pc<=ALUOut. Pulse instr_done -> FETCH.
  - ADDIEX: ALUOut<=A+signimm -> ADDIWB.
  - ADDIWB: rt<=ALUOut, pulse instr_done -> FETCH.
  - JUMP: pc<={pc[31:28], instr[25:0], 2'b00}, pc already +4. Pulse instr_done -> FETCH.
- Latency with zero wait states, reset/FETCH entry to instr_done:
  - lw 5 cycles
  - sw, R-type, addi 4 cycles
  - beq, j 3 cycles
  - Each wait cycle (mem_req=1, mem_ready=0) adds exactly 1 cycle.
- Arithmetic:
  - Wrap-around modulo 2**MIPS_SIZE; no overflow traps.
  - slt is signed.
  - signimm = sign-extended instr[15:0].
- mem_ready while mem_req=0 is ignored.
- mem_addr, mem_wdata and mem_we are stable while mem_req is held.
- Reset asserted mid-access: mem_req drops immediately (async); the access is abandoned.
- Outputs instr_done and illegal_instr are registered.

Decomposition:
- Package mips_mc_pkg holds:
  - state enum
  - opcode constants: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010
  - funct constants: add 100000, sub 100010, and 100100, or 100101, slt 101010
  - ALU code constants
- One sub-module: mips_mc_ctrl, the FSM. Inputs: opcode, funct, mem_ready, zero. Outputs: mux selects, register enables, ALU code, mem_req/mem_we, pulses.
- Datapath and register file stay in mips_multicycle_core.

Test Plan:
1. Reset: hold RST=0 3 cycles, release -> pc=0, mem_req=1, mem_addr=0, mem_we=0 on the first cycle; no instr_done.
2. addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1 with zero-wait memory:
   - Required: $3=2, $4=1.
   - instr_done every 4 cycles; pc=16 after the fourth.
3. sw $3,8($0) then lw $5,8($0):
   - Write cycle shows mem_addr=8, mem_we=1, mem_wdata=2.
   - $5=2 after 5 cycles.
   - $0 remains 0 after addi $0,$0,7.
4. beq $1,$1,+2 at pc=0x20 -> pc=0x2C. j 0x40 at 0x2C -> pc=0x100. beq not taken -> pc=instr+4. Each takes 3 cycles.
5. mem_ready low 3 cycles during FETCH and MEMRD of a lw:
   - mem_addr stable throughout.
   - instr_done arrives at 11 cycles.
   - No register changes during waits.
6. Opcode 111111 -> illegal_instr pulse on the 2nd cycle, no register write, next fetch at pc+4. Reset asserted during MEMWR wait -> mem_req=0 same cycle, pc=RESET_PC.
